// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default memory window (RESET_PC_DEFAULT, MEM_BYTES_DEFAULT)
//   - datapath widths (ADDR_W, INSTR_W), NOP word, PC step and alignment mask
//   - fetch_entry_t: one buffered fetch result {pc, instr, fault}
//   - pc_in_window(): window membership test used to flag out-of-range fetches
package fetch_pkg;

    localparam int unsigned ADDR_W            = 32;
    localparam int unsigned INSTR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h8002_0000;
    localparam int unsigned MEM_BYTES_DEFAULT = 1024;
    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_entry_t;

    // Unsigned offset from the base: addresses below the base wrap to a huge
    // offset, so one compare covers both ends of the window.
    function automatic logic pc_in_window(
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] bytes
    );
        logic [ADDR_W-1:0] offset;
        offset = pc - base;
        return (offset < bytes);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch_entry_t, organised as a head register
// and a tail register so the head drives the stage outputs straight from flops.
//   clock, reset_n : clock and async active-low reset
//   push, din      : write request and data
//   pop            : consume the head (ignored when empty)
//   flush          : drop all entries; takes priority over push
//   head, valid    : current head entry and its validity
//   count          : occupancy 0..2
// When the buffer empties (pop or flush) the head register keeps its last
// contents so downstream sees stable, X-free values while valid is low.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         valid,
    output logic [1:0]   count
);

    fetch_entry_t head_r, head_nxt_s;
    fetch_entry_t tail_r, tail_nxt_s;
    logic [1:0]   count_r, count_nxt_s;
    logic         valid_r, valid_nxt_s;
    logic         pop_ok_s;

    // Next-state computation for occupancy and the two entry registers.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        pop_ok_s    = pop && (count_r != 2'd0);
        if (flush) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd2) begin
                        // Full without a pop: drop the write rather than corrupt state.
                        count_nxt_s = count_r;
                    end else if (count_r == 2'd0) begin
                        head_nxt_s  = din;
                        count_nxt_s = count_r + 2'd1;
                    end else begin
                        tail_nxt_s  = din;
                        count_nxt_s = count_r + 2'd1;
                    end
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_nxt_s = tail_r;
                    end else begin
                        head_nxt_s = head_r;
                    end
                    count_nxt_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_nxt_s = din;
                    end else begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = din;
                    end
                    count_nxt_s = count_r;
                end
                default: begin
                    count_nxt_s = count_r;
                end
            endcase
        end
        valid_nxt_s = (count_nxt_s != 2'd0);
    end

    // Entry and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign count = count_r;

    fetch_fifo_chk u_chk (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop_ok_s),
        .flush   (flush),
        .count   (count_r)
    );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Invariant checker for fetch_fifo.
//   clock, reset_n : clock and async active-low reset
//   push, pop      : FIFO request strobes (pop already qualified by valid)
//   flush          : discard-all request
//   count          : current occupancy
module fetch_fifo_chk (
    input logic       clock,
    input logic       reset_n,
    input logic       push,
    input logic       pop,
    input logic       flush,
    input logic [1:0] count
);

    // A push may only land on a full buffer if the head leaves on the same edge.
    assert property (@(posedge clock) disable iff (!reset_n)
        (push && !flush) |-> (pop || (count != 2'd2)));

    // Occupancy never exceeds the two physical entries.
    assert property (@(posedge clock) disable iff (!reset_n)
        count != 2'd3);

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// absorbs the memory's one-cycle read latency and hands {pc, instr, fault} to
// decode through a two-entry buffer with a valid/ready handshake.
//   clock, reset_n          : clock and async active-low reset
//   imem_addr / imem_data   : memory address (the PC) and data one cycle later
//   redirect_valid/_pc      : restart fetch at a new, word-aligned PC
//   out_valid/out_ready     : handshake to decode
//   out_pc/out_instr/out_fault : head entry; faulting fetches carry a NOP word
module ifetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_fault
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT    = ADDR_W'(MEM_BYTES);
    localparam logic [2:0]        CREDIT_LIMIT = 3'(FIFO_DEPTH);

    logic [ADDR_W-1:0] pc_r, pc_nxt_s;
    logic [ADDR_W-1:0] inflight_pc_r, inflight_pc_nxt_s;
    logic              inflight_r, inflight_nxt_s;
    logic              pop_s, issue_s, push_s, fault_s;
    logic [2:0]        credit_s, limit_s;
    logic [1:0]        count_s;
    logic              fifo_valid_s;
    fetch_entry_t      push_entry_s, head_s;

    // Handshake, issue credit check and the entry built from the returning word.
    always_comb begin
        pop_s    = fifo_valid_s && out_ready;
        // Buffered + in-flight entries, less the one leaving this edge, must
        // leave room for one more so the word we issue always has a slot.
        credit_s = {1'b0, count_s} + {2'b00, inflight_r};
        limit_s  = CREDIT_LIMIT + {2'b00, pop_s};
        issue_s  = !redirect_valid && (credit_s < limit_s);
        push_s   = inflight_r && !redirect_valid;
        fault_s  = !pc_in_window(inflight_pc_r, RESET_PC, MEM_LIMIT);
        push_entry_s.pc = inflight_pc_r;
        if (fault_s) begin
            push_entry_s.instr = NOP;
        end else begin
            push_entry_s.instr = imem_data;
        end
        push_entry_s.fault = fault_s;
    end

    // Next PC and in-flight tracking; a redirect drops the outstanding word.
    always_comb begin
        pc_nxt_s          = pc_r;
        inflight_nxt_s    = inflight_r;
        inflight_pc_nxt_s = inflight_pc_r;
        if (redirect_valid) begin
            pc_nxt_s       = redirect_pc & PC_ALIGN_MASK;
            inflight_nxt_s = 1'b0;
        end else if (issue_s) begin
            pc_nxt_s          = pc_r + PC_STEP;
            inflight_nxt_s    = 1'b1;
            inflight_pc_nxt_s = pc_r;
        end else begin
            // Any outstanding word is pushed on this edge.
            inflight_nxt_s = 1'b0;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= RESET_PC;
        end else begin
            pc_r          <= pc_nxt_s;
            inflight_r    <= inflight_nxt_s;
            inflight_pc_r <= inflight_pc_nxt_s;
        end
    end

    fetch_fifo u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .din     (push_entry_s),
        .pop     (pop_s),
        .flush   (redirect_valid),
        .head    (head_s),
        .valid   (fifo_valid_s),
        .count   (count_s)
    );

    assign imem_addr = pc_r;
    assign out_valid = fifo_valid_s;
    assign out_pc    = head_s.pc;
    assign out_instr = head_s.instr;
    assign out_fault = head_s.fault;

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_pc;
        int          n;
        logic [3:0]  fmask;
        bit          with_pop;
        logic [31:0] head_pc;
        bit          head_fault;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    ifetch_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_fault      (out_fault)
    );

    always #5 clock = ~clock;

    // Registered instruction memory: word = byte address inside the window.
    always @(posedge clock) begin
        if ((imem_addr - 32'h8002_0000) < 32'd1024) imem_data <= imem_addr;
        else imem_data <= 32'hDEAD_BEEF;
    end

    // Scoreboard monitor: every accepted head is compared with the queue front.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t e;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_extra: got pc=%h instr=%h fault=%b, expected no delivery",
                         out_pc, out_instr, out_fault);
            end else begin
                e = sb_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault) begin
                    n_fail++;
                    $display("FAIL stream: got pc=%h instr=%h fault=%b, expected pc=%h instr=%h fault=%b",
                             out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input bit fault);
        exp_t e;
        e.pc    = pc;
        e.instr = fault ? 32'h0 : pc;
        e.fault = fault;
        sb_q.push_back(e);
    endtask

    // Precondition: reset_n low, out_ready high. Takes n entries from RESET_PC.
    task automatic release_and_take(input int n);
        for (int k = 0; k < n; k++) expect_entry(32'h8002_0000 + 32'(4 * k), 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("rel_valid_e1", {31'h0, out_valid}, 32'h0);
        @(posedge clock); #1;
        check("rel_valid_e2", {31'h0, out_valid}, 32'h1);
        check("rel_pc_e2", out_pc, 32'h8002_0000);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #1;
            if (k < n - 1) check("rel_no_gap", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b0;
    endtask

    // Precondition: out_ready low. Fills the buffer, redirects, takes n entries.
    task automatic do_redirect(input vec_t v);
        repeat (2) @(posedge clock);
        #1;
        if (v.with_pop) expect_entry(v.head_pc, v.head_fault);
        for (int k = 0; k < v.n; k++) expect_entry(v.exp_pc + 32'(4 * k), v.fmask[k]);
        redirect_valid = 1'b1;
        redirect_pc    = v.target;
        out_ready      = v.with_pop;
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("redir_valid_e0", {31'h0, out_valid}, 32'h0);
        @(posedge clock); #1;
        check("redir_valid_e1", {31'h0, out_valid}, 32'h0);
        @(posedge clock); #1;
        check("redir_valid_e2", {31'h0, out_valid}, 32'h1);
        check("redir_pc_e2", out_pc, v.exp_pc);
        for (int k = 0; k < v.n; k++) begin
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{target:32'h8002_0103, exp_pc:32'h8002_0100, n:3, fmask:4'b0000,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[1] = '{target:32'h8002_0200, exp_pc:32'h8002_0200, n:2, fmask:4'b0000,
                    with_pop:1'b1, head_pc:32'h8002_010C, head_fault:1'b0};
        vecs[2] = '{target:32'h8002_0400, exp_pc:32'h8002_0400, n:2, fmask:4'b0011,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[3] = '{target:32'h8002_0000, exp_pc:32'h8002_0000, n:2, fmask:4'b0000,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[4] = '{target:32'h8002_03F8, exp_pc:32'h8002_03F8, n:3, fmask:4'b0100,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[5] = '{target:32'h8001_FFFE, exp_pc:32'h8001_FFFC, n:2, fmask:4'b0001,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[6] = '{target:32'hFFFF_FFFC, exp_pc:32'hFFFF_FFFC, n:2, fmask:4'b0011,
                    with_pop:1'b0, head_pc:32'h0, head_fault:1'b0};
        vecs[7] = '{target:32'h8002_0010, exp_pc:32'h8002_0010, n:2, fmask:4'b0000,
                    with_pop:1'b1, head_pc:32'h0000_0004, head_fault:1'b1};

        // Reset state.
        #1 reset_n = 1'b0;
        #3;
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_fault", {31'h0, out_fault}, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h8002_0000);

        // Streaming from reset with decode always ready.
        out_ready = 1'b1;
        release_and_take(6);

        // Redirect vectors (full buffer, coincident pop, window edges, wrap).
        for (int i = 0; i < 8; i++) do_redirect(vecs[i]);

        // Back-pressure from reset: buffer fills, PC freezes.
        @(posedge clock); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock); #1;
            if (k >= 3) begin
                check("hold_imem_addr", imem_addr, 32'h8002_0008);
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_pc", out_pc, 32'h8002_0000);
            end
        end
        expect_entry(32'h8002_0000, 1'b0);
        expect_entry(32'h8002_0004, 1'b0);
        expect_entry(32'h8002_0008, 1'b0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (k < 2) check("drain_no_gap", {31'h0, out_valid}, 32'h1);
        end
        out_ready = 1'b0;

        // Asynchronous reset mid-stream with a full buffer.
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 32'h0);
        check("async_rst_imem_addr", imem_addr, 32'h8002_0000);
        check("async_rst_pc", out_pc, 32'h0);
        out_ready = 1'b1;
        release_and_take(3);

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
